hamming_serial_secded_decoder: RTL and testbench

//   Parametrised bit-serial Hamming decoder; successor to the fixed (7,4) serial decoder.

---
 rtl/hamming_serial_secded_decoder_if.sv | 39 +++
 rtl/hamming_serial_secded_decoder.sv | 145 ++++++++++++++
 tb/tb_hamming_serial_secded_decoder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_serial_secded_decoder_if.sv
// Interface for the bit-serial Hamming decoder: serial bit input side plus the
// valid/ready word output side. The slave modport is the decoder's view.
// Widths track the SECDED_EN build option so they match the decoder.
interface hamming_serial_secded_decoder_if #(
  parameter int unsigned PAR_W = 3
) ();
  localparam int unsigned DATA_W = 2**PAR_W - 1 - PAR_W;
`ifdef SECDED_EN
  localparam int unsigned CODE_W = 2**PAR_W;
`else
  localparam int unsigned CODE_W = 2**PAR_W - 1;
`endif
  localparam int unsigned CNT_W = $clog2(CODE_W + 1);

  logic              ena;
  logic              bit_in;
  logic              bit_valid;
  logic              frame_start;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_corrected;
  logic              err_uncorrectable;
  logic [PAR_W-1:0]  syndrome_out;
  logic [CNT_W-1:0]  bit_count_out;
  logic              overrun;

  modport slave (
    input  ena, bit_in, bit_valid, frame_start, out_ready,
    output out_valid, data_out, err_corrected, err_uncorrectable, syndrome_out,
           bit_count_out, overrun
  );

  modport master (
    output ena, bit_in, bit_valid, frame_start, out_ready,
    input  out_valid, data_out, err_corrected, err_uncorrectable, syndrome_out,
           bit_count_out, overrun
  );
endinterface

// File: rtl/hamming_serial_secded_decoder.sv
// Bit-serial Hamming decoder. Collects CODE_W code bits (position 1 first),
// holds the completed frame in a one-cycle decode stage, then loads a 1-entry
// output register presented on a valid/ready handshake.
// Build option: define SECDED_EN to add a trailing overall-parity bit and
// double-error detection; undefined gives plain single-error correction.
module hamming_serial_secded_decoder #(
  parameter int unsigned PAR_W = 3
) (
  input logic                            clk,
  input logic                            rst_n,
  hamming_serial_secded_decoder_if.slave bus
);
  localparam int unsigned DATA_W = 2**PAR_W - 1 - PAR_W;
  localparam int unsigned NPOS   = 2**PAR_W - 1;
`ifdef SECDED_EN
  localparam int unsigned CODE_W = 2**PAR_W;
`else
  localparam int unsigned CODE_W = 2**PAR_W - 1;
`endif
  localparam int unsigned CNT_W = $clog2(CODE_W + 1);

  // Code position (1-based) of the k-th data bit, data LSB first.
  function automatic int unsigned data_pos(int unsigned k);
    int unsigned n;
    n = 0;
    data_pos = 0;
    for (int unsigned p = 3; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) data_pos = p;
        n++;
      end
    end
  endfunction

  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_done;
  logic [CODE_W-1:0] dec_code_q;
  logic              dec_valid_q;
  logic [PAR_W-1:0]  syn;
  logic              fix, corr_flag, unc_flag;
  logic [DATA_W-1:0] data_fixed;
  logic              out_valid_q;
  logic [DATA_W-1:0] data_q;
  logic              err_c_q, err_u_q, overrun_q;
  logic [PAR_W-1:0]  syn_q;

  // Serial collection: store the incoming bit at position cnt+1, wrap at CODE_W.
  always_comb begin
    code_d     = code_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    if (bus.ena) begin
      if (bus.frame_start) begin
        cnt_d = '0;
        if (bus.bit_valid) begin
          code_d[0] = bus.bit_in;
          cnt_d     = CNT_W'(1);
        end
      end else if (bus.bit_valid) begin
        for (int unsigned i = 0; i < CODE_W; i++) begin
          if (cnt_q == CNT_W'(i)) code_d[i] = bus.bit_in;
        end
        if (cnt_q == CNT_W'(CODE_W - 1)) begin
          cnt_d      = '0;
          frame_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Collection state and decode-stage capture of each completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= '0;
      cnt_q       <= '0;
      dec_code_q  <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      dec_valid_q <= frame_done;
      if (frame_done) dec_code_q <= code_d;
    end
  end

  // Syndrome, error classification and corrected data for the decode stage.
  always_comb begin
    syn = '0;
    for (int unsigned p = 1; p <= NPOS; p++) begin
      if (dec_code_q[p-1]) syn = syn ^ PAR_W'(p);
    end
`ifdef SECDED_EN
    // Odd overall parity means an odd number of flips; even with syn!=0 is a double error.
    fix       = (syn != '0) && (^dec_code_q);
    corr_flag = ^dec_code_q;
    unc_flag  = (syn != '0) && !(^dec_code_q);
`else
    fix       = (syn != '0);
    corr_flag = fix;
    unc_flag  = 1'b0;
`endif
    data_fixed = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      data_fixed[k] = dec_code_q[data_pos(k)-1] ^ (fix && (syn == PAR_W'(data_pos(k))));
    end
  end

  // Output register: load when empty or being drained, otherwise drop and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_c_q     <= 1'b0;
      err_u_q     <= 1'b0;
      syn_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (dec_valid_q) begin
        if (!out_valid_q || bus.out_ready) begin
          out_valid_q <= 1'b1;
          data_q      <= data_fixed;
          err_c_q     <= corr_flag;
          err_u_q     <= unc_flag;
          syn_q       <= syn;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.data_out          = data_q;
  assign bus.err_corrected     = err_c_q;
  assign bus.err_uncorrectable = err_u_q;
  assign bus.syndrome_out      = syn_q;
  assign bus.bit_count_out     = cnt_q;
  assign bus.overrun           = overrun_q;
endmodule

// File: tb/tb_hamming_serial_secded_decoder.sv
// Directed bench for hamming_serial_secded_decoder: PAR_W=3 and PAR_W=4 instances.
// SECDED_EN selects the same build option as the design.
module tb_hamming_serial_secded_decoder;
`ifdef SECDED_EN
  localparam int CODE3 = 8;
  localparam int CODE4 = 16;
`else
  localparam int CODE3 = 7;
  localparam int CODE4 = 15;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   ovr_cnt = 0;
  int   ovr_base;

  always #5 clk = ~clk;

  hamming_serial_secded_decoder_if #(.PAR_W(3)) b3 ();
  hamming_serial_secded_decoder_if #(.PAR_W(4)) b4 ();

  hamming_serial_secded_decoder #(.PAR_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  hamming_serial_secded_decoder #(.PAR_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // Overrun pulses observed away from the active edge.
  always @(negedge clk) if (b3.overrun === 1'b1) ovr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Append even overall parity in the SECDED build.
  function automatic logic [8:1] mk3(input logic [7:1] c);
    mk3 = {1'b0, c};
`ifdef SECDED_EN
    mk3[8] = ^c;
`endif
  endfunction

  // Hamming(15,11) encoder: data at non-power-of-2 positions, LSB first.
  function automatic logic [16:1] enc4(input logic [10:0] d);
    int k;
    logic par;
    enc4 = '0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        enc4[p] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++) if (((p >> i) & 1) != 0) par = par ^ enc4[p];
      enc4[1 << i] = par;
    end
`ifdef SECDED_EN
    enc4[16] = ^enc4[15:1];
`endif
  endfunction

  task automatic send3(input logic [8:1] code, input int n, input bit fs);
    for (int i = 1; i <= n; i++) begin
      b3.bit_in      = code[i];
      b3.bit_valid   = 1'b1;
      b3.frame_start = fs && (i == 1);
      @(posedge clk); #1;
    end
    b3.bit_valid   = 1'b0;
    b3.frame_start = 1'b0;
  endtask

  task automatic send4(input logic [16:1] code);
    for (int i = 1; i <= CODE4; i++) begin
      b4.bit_in    = code[i];
      b4.bit_valid = 1'b1;
      @(posedge clk); #1;
    end
    b4.bit_valid = 1'b0;
  endtask

  task automatic wait3(input string tag);
    int n = 0;
    while (b3.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(b3.out_valid), 32'd1);
  endtask

  task automatic wait4(input string tag);
    int n = 0;
    while (b4.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(b4.out_valid), 32'd1);
  endtask

  task automatic accept3();
    b3.out_ready = 1'b1;
    @(posedge clk); #1;
    b3.out_ready = 1'b0;
  endtask

  task automatic accept4();
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] d4;
    logic [16:1] c4;
    b3.ena = 1'b1; b3.bit_in = 1'b0; b3.bit_valid = 1'b0; b3.frame_start = 1'b0;
    b3.out_ready = 1'b0;
    b4.ena = 1'b1; b4.bit_in = 1'b0; b4.bit_valid = 1'b0; b4.frame_start = 1'b0;
    b4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(b3.out_valid), 32'd0);
    check("rst_data", 32'(b3.data_out), 32'd0);
    check("rst_count", 32'(b3.bit_count_out), 32'd0);
    check("rst_ovr", 32'(b3.overrun), 32'd0);
    check("rst_corr", 32'(b3.err_corrected), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean frame, one-edge latency after the last bit.
    send3(mk3(7'b1010101), CODE3, 1'b0);
    check("t1_early", 32'(b3.out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid", 32'(b3.out_valid), 32'd1);
    check("t1_data", 32'(b3.data_out), 32'hB);
    check("t1_syn", 32'(b3.syndrome_out), 32'd0);
    check("t1_corr", 32'(b3.err_corrected), 32'd0);
    check("t1_unc", 32'(b3.err_uncorrectable), 32'd0);
    accept3();
    check("t1_drain", 32'(b3.out_valid), 32'd0);

    // Single error at position 5.
    send3(mk3(7'b1000101), CODE3, 1'b0);
    wait3("t2");
    check("t2_data", 32'(b3.data_out), 32'hB);
    check("t2_syn", 32'(b3.syndrome_out), 32'd5);
    check("t2_corr", 32'(b3.err_corrected), 32'd1);
    check("t2_unc", 32'(b3.err_uncorrectable), 32'd0);
    accept3();

`ifdef SECDED_EN
    // Double error at positions 2 and 6.
    send3(8'b01110111, 8, 1'b0);
    wait3("t3");
    check("t3_syn", 32'(b3.syndrome_out), 32'd4);
    check("t3_unc", 32'(b3.err_uncorrectable), 32'd1);
    check("t3_corr", 32'(b3.err_corrected), 32'd0);
    check("t3_data", 32'(b3.data_out), 32'hF);
    accept3();
`endif

    // Backpressure: second frame is dropped with one overrun pulse.
    ovr_base = ovr_cnt;
    send3(mk3(7'b1010101), CODE3, 1'b0);
    wait3("t4a");
    send3(mk3(7'b0000000), CODE3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ovr", 32'(ovr_cnt - ovr_base), 32'd1);
    check("t4_held_valid", 32'(b3.out_valid), 32'd1);
    check("t4_held_data", 32'(b3.data_out), 32'hB);
    accept3();
    check("t4_drain", 32'(b3.out_valid), 32'd0);

    // ena low: bits ignored, counter holds.
    b3.ena = 1'b0;
    b3.bit_valid = 1'b1;
    b3.bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b3.bit_valid = 1'b0;
    b3.ena = 1'b1;
    check("ena_count", 32'(b3.bit_count_out), 32'd0);

    // Resync after a partial frame.
    send3(mk3(7'b0000111), 3, 1'b0);
    check("t5_partial", 32'(b3.bit_count_out), 32'd3);
    send3(mk3(7'b1010101), CODE3, 1'b1);
    wait3("t5");
    check("t5_data", 32'(b3.data_out), 32'hB);
    check("t5_syn", 32'(b3.syndrome_out), 32'd0);

    // Reset mid-frame while a word is held.
    send3(mk3(7'b1100110), 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(b3.out_valid), 32'd0);
    check("t5_rst_data", 32'(b3.data_out), 32'd0);
    check("t5_rst_count", 32'(b3.bit_count_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // PAR_W=4: clean word, then every single-position flip.
    d4 = 11'h5A3;
    send4(enc4(d4));
    wait4("t6c");
    check("t6c_data", 32'(b4.data_out), 32'(d4));
    check("t6c_syn", 32'(b4.syndrome_out), 32'd0);
    check("t6c_corr", 32'(b4.err_corrected), 32'd0);
    accept4();
    for (int p = 1; p <= 15; p++) begin
      d4 = 11'($urandom);
      c4 = enc4(d4);
      c4[p] = ~c4[p];
      send4(c4);
      wait4("t6");
      check("t6_data", 32'(b4.data_out), 32'(d4));
      check("t6_syn", 32'(b4.syndrome_out), 32'(p));
      check("t6_corr", 32'(b4.err_corrected), 32'd1);
      accept4();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
